// File: rtl/eindopdracht_mult_seq_pkg.sv
// rtl/eindopdracht_mult_seq_pkg.sv - shared types and constants for the sequential 32x32 multiplier
package eindopdracht_mult_seq_pkg;

  localparam int HALF_W = 16;
  localparam int OP_W   = 32;
  localparam int RES_W  = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } tag_t;

  // Partial-product weight per issue index: lo*lo, hi*lo, lo*hi, hi*hi
  localparam logic [3:0][5:0] PP_SHIFT = {6'd32, 6'd16, 6'd16, 6'd0};

endpackage

// File: rtl/eindopdracht_mult_seq_acc.sv
// rtl/eindopdracht_mult_seq_acc.sv - product tag pipeline and 64-bit partial-product accumulator
module eindopdracht_mult_seq_acc
  import eindopdracht_mult_seq_pkg::*;
#(
  parameter int MUL_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             issue_valid,
  input  logic [1:0]       issue_idx,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  input  logic             op_signed,
  input  logic [OP_W-1:0]  mul_p,
  output logic [RES_W-1:0] acc,
  output logic             last_done
);

  tag_t             tag_q [MUL_LATENCY];
  tag_t             tag_out;
  logic [RES_W-1:0] pp;
  logic [RES_W-1:0] corr;

  assign tag_out = tag_q[MUL_LATENCY-1];

  // Signed correction rides along with the hi*hi product so no extra cycle is spent
  always_comb begin
    pp   = {{(RES_W-OP_W){1'b0}}, mul_p} << PP_SHIFT[tag_out.idx];
    corr = '0;
    if (op_signed && (tag_out.idx == 2'd3)) begin
      if (op_a[OP_W-1]) corr = corr + {op_b, {OP_W{1'b0}}};
      if (op_b[OP_W-1]) corr = corr + {op_a, {OP_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MUL_LATENCY; i++) tag_q[i] <= '0;
      acc       <= '0;
      last_done <= 1'b0;
    end else begin
      tag_q[0].valid <= issue_valid;
      tag_q[0].idx   <= issue_idx;
      for (int i = 1; i < MUL_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      last_done <= tag_out.valid && (tag_out.idx == 2'd3);
      if (clear) acc <= '0;
      else if (tag_out.valid) acc <= acc + pp - corr;
    end
  end

endmodule

// File: rtl/eindopdracht_mult_seq.sv
// rtl/eindopdracht_mult_seq.sv - 32x32 multiplier over a shared 16x16 cell; MULT_SEQ_SIGNED_EN adds signed mode
module eindopdracht_mult_seq
  import eindopdracht_mult_seq_pkg::*;
#(
  parameter int MUL_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_src1,
  input  logic [OP_W-1:0]   req_src2,
`ifdef MULT_SEQ_SIGNED_EN
  input  logic              req_signed,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [HALF_W-1:0] mul_a,
  output logic [HALF_W-1:0] mul_b,
  input  logic [OP_W-1:0]   mul_p
);

  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d, cnt_nxt;
  logic [OP_W-1:0]    a_q, b_q;
  logic               signed_q, signed_in;
  logic               accept;
  logic [HALF_W-1:0]  mul_a_d, mul_b_d;
  logic               rsp_valid_d;
  logic [RES_W-1:0]   rsp_result_d;
  logic [RES_W-1:0]   acc;
  logic               last_done;

`ifdef MULT_SEQ_SIGNED_EN
  assign signed_in = req_signed;
`else
  assign signed_in = 1'b0;
`endif

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign cnt_nxt   = cnt_q + 2'd1;

  // Index bit 0 picks the A half, bit 1 the B half
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_a_d      = '0;
    mul_b_d      = '0;
    rsp_valid_d  = rsp_valid;
    rsp_result_d = rsp_result;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          cnt_d   = 2'd0;
          mul_a_d = req_src1[HALF_W-1:0];
          mul_b_d = req_src2[HALF_W-1:0];
        end
      end
      ST_ISSUE: begin
        if (cnt_q == 2'd3) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d   = cnt_nxt;
          mul_a_d = cnt_nxt[0] ? a_q[OP_W-1:HALF_W] : a_q[HALF_W-1:0];
          mul_b_d = cnt_nxt[1] ? b_q[OP_W-1:HALF_W] : b_q[HALF_W-1:0];
        end
      end
      ST_DRAIN: begin
        if (last_done) begin
          state_d      = ST_DONE;
          rsp_valid_d  = 1'b1;
          rsp_result_d = acc;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      a_q        <= '0;
      b_q        <= '0;
      signed_q   <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mul_a      <= mul_a_d;
      mul_b      <= mul_b_d;
      rsp_valid  <= rsp_valid_d;
      rsp_result <= rsp_result_d;
      if (accept) begin
        a_q      <= req_src1;
        b_q      <= req_src2;
        signed_q <= signed_in;
      end
    end
  end

  eindopdracht_mult_seq_acc #(
    .MUL_LATENCY(MUL_LATENCY)
  ) u_acc (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (accept),
    .issue_valid(state_q == ST_ISSUE),
    .issue_idx  (cnt_q),
    .op_a       (a_q),
    .op_b       (b_q),
    .op_signed  (signed_q),
    .mul_p      (mul_p),
    .acc        (acc),
    .last_done  (last_done)
  );

endmodule

// File: tb/tb_eindopdracht_mult_seq.sv
// tb/tb_eindopdracht_mult_seq.sv - self-checking bench for eindopdracht_mult_seq at latency 1 and 3
module tb_eindopdracht_mult_seq;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req_valid, req_ready, req_signed, rsp_valid, rsp_ready;
  logic [31:0] req_src1, req_src2, mul_p;
  logic [63:0] rsp_result;
  logic [15:0] mul_a, mul_b;

  logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3;
  logic [31:0] src1_3, src2_3, mul_p3;
  logic [63:0] rsp_result3;
  logic [15:0] mul_a3, mul_b3;

  logic [31:0] cell1 [LAT];
  logic [31:0] cell3 [LAT3];

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] seq_a [6];
  logic [15:0] seq_b [6];

  eindopdracht_mult_seq #(.MUL_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2),
`ifdef MULT_SEQ_SIGNED_EN
    .req_signed(req_signed),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  eindopdracht_mult_seq #(.MUL_LATENCY(LAT3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_src1(src1_3), .req_src2(src2_3),
`ifdef MULT_SEQ_SIGNED_EN
    .req_signed(1'b0),
`endif
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .mul_a(mul_a3), .mul_b(mul_b3), .mul_p(mul_p3)
  );

  // Shared 16x16 cells: plain pipelines with no reset, so in-flight products survive a reset
  always @(posedge clk) begin
    cell1[0] <= 32'(mul_a) * 32'(mul_b);
    for (int i = 1; i < LAT; i++) cell1[i] <= cell1[i-1];
  end
  always @(posedge clk) begin
    cell3[0] <= 32'(mul_a3) * 32'(mul_b3);
    for (int i = 1; i < LAT3; i++) cell3[i] <= cell3[i-1];
  end
  assign mul_p  = cell1[LAT-1];
  assign mul_p3 = cell3[LAT3-1];

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int hold,
                       output logic [63:0] res, output int lat);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    req_src1 = a; req_src2 = b; req_signed = sgn; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seq_a[0] = mul_a; seq_b[0] = mul_b;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat < 6) begin seq_a[lat] = mul_a; seq_b[lat] = mul_b; end
    end
    res = rsp_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== res || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable: cyc %0d valid=%b result=%h ready=%b want valid=1 result=%h ready=0",
                 i, rsp_valid, rsp_result, req_ready, res);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL after_handshake: ready=%b valid=%b want ready=1 valid=0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_result !== 64'd0 || mul_a !== 16'd0 || mul_b !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b valid=%b result=%h a=%h b=%h want 1 0 0 0 0",
               req_ready, rsp_valid, rsp_result, mul_a, mul_b);
    end
  endtask

  task automatic test_max();
    logic [63:0] r; int lat;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, r, lat);
    n_checks++;
    if (r !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL max_result: got %h want fffffffe00000001", r); end
    n_checks++;
    if (lat !== 5 + LAT) begin n_fail++; $display("FAIL max_latency: got %0d want %0d", lat, 5 + LAT); end
  endtask

  task automatic test_mul_seq();
    logic [63:0] r; int lat;
    logic [15:0] ea [5];
    logic [15:0] eb [5];
    ea = '{16'h2345, 16'h0001, 16'h2345, 16'h0001, 16'h0000};
    eb = '{16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0000};
    do_op(32'h0001_2345, 32'h0001_0000, 1'b0, 0, r, lat);
    n_checks++;
    if (r !== 64'h0000_0001_2345_0000) begin n_fail++; $display("FAIL seq_result: got %h want 0000000123450000", r); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (seq_a[i] !== ea[i] || seq_b[i] !== eb[i]) begin
        n_fail++; $display("FAIL mul_seq[%0d]: got %h/%h want %h/%h", i, seq_a[i], seq_b[i], ea[i], eb[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] r; int lat;
    do_op(32'd3, 32'd5, 1'b0, 10, r, lat);
    n_checks++;
    if (r !== 64'd15) begin n_fail++; $display("FAIL bp_result: got %0d want 15", r); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r; int lat;
    @(negedge clk);
    req_src1 = 32'h1234_5678; req_src2 = 32'h9ABC_DEF1; req_signed = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (mul_a !== 16'h5678 || mul_b !== 16'h9ABC) begin
      n_fail++; $display("FAIL issue3_operands: got %h/%h want 5678/9abc", mul_a, mul_b);
    end
    reset_n = 1'b0; #1;
    test_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_op(32'd2, 32'd3, 1'b0, 0, r, lat);
    n_checks++;
    if (r !== 64'd6) begin n_fail++; $display("FAIL post_reset_result: got %0d want 6", r); end
    n_checks++;
    if (lat !== 5 + LAT) begin n_fail++; $display("FAIL post_reset_latency: got %0d want %0d", lat, 5 + LAT); end
  endtask

`ifdef MULT_SEQ_SIGNED_EN
  task automatic test_signed();
    logic [63:0] r; int lat;
    do_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 0, r, lat);
    n_checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL signed_result: got %h want fffffffffffffffe", r); end
    n_checks++;
    if (lat !== 5 + LAT) begin n_fail++; $display("FAIL signed_latency: got %0d want %0d", lat, 5 + LAT); end
    do_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 0, r, lat);
    n_checks++;
    if (r !== 64'h0000_0001_FFFF_FFFE) begin n_fail++; $display("FAIL unsigned_mode: got %h want 00000001fffffffe", r); end
  endtask
`endif

  task automatic test_random();
    logic [63:0] r, exp; int lat;
    logic [31:0] a, b; logic sgn;
    for (int i = 0; i < 24; i++) begin
      a = (i == 0) ? 32'd0 : $urandom;
      b = (i == 1) ? 32'd0 : $urandom;
`ifdef MULT_SEQ_SIGNED_EN
      sgn = 1'($urandom_range(0, 1));
`else
      sgn = 1'b0;
`endif
      exp = ref_mul(a, b, sgn);
      do_op(a, b, sgn, $urandom_range(0, 3), r, lat);
      n_checks++;
      if (r !== exp || lat !== 5 + LAT) begin
        n_fail++; $display("FAIL random[%0d]: %h*%h s=%b got %h lat %0d want %h lat %0d", i, a, b, sgn, r, lat, exp, 5 + LAT);
      end
    end
  endtask

  task automatic test_latency3();
    logic [31:0] a, b; logic [63:0] exp; int lat;
    for (int i = 0; i < 5; i++) begin
      a = (i == 0) ? 32'd7 : $urandom;
      b = (i == 0) ? 32'd9 : $urandom;
      exp = ref_mul(a, b, 1'b0);
      @(negedge clk);
      src1_3 = a; src2_3 = b; req_valid3 = 1'b1;
      @(posedge clk); #1;
      req_valid3 = 1'b0;
      lat = 0;
      while (!rsp_valid3 && lat < 40) begin @(posedge clk); #1; lat++; end
      n_checks++;
      if (rsp_result3 !== exp || lat !== 5 + LAT3) begin
        n_fail++; $display("FAIL lat3[%0d]: %h*%h got %h lat %0d want %h lat %0d", i, a, b, rsp_result3, lat, exp, 5 + LAT3);
      end
      rsp_ready3 = 1'b1;
      @(posedge clk); #1;
      rsp_ready3 = 1'b0;
      n_checks++;
      if (req_ready3 !== 1'b1) begin n_fail++; $display("FAIL lat3_ready[%0d]: got %b want 1", i, req_ready3); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_src1 = '0; req_src2 = '0; req_signed = 1'b0; rsp_ready = 1'b0;
    req_valid3 = 1'b0; src1_3 = '0; src2_3 = '0; rsp_ready3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    test_max();
    test_mul_seq();
    test_backpressure();
    test_reset_mid();
`ifdef MULT_SEQ_SIGNED_EN
    test_signed();
`endif
    test_random();
    test_latency3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/eindopdracht_mult_seq.md
EINDOPDRACHT_MULT_SEQ -- requirements
Module: eindopdracht_mult_seq

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 1: clock cycles from mul_a/mul_b to the matching mul_p of the external 16x16 cell; legal values 1..4.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when high with req_valid.
- req_src1  in  32  multiplicand.
- req_src2  in  32  multiplier.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_result  out  64  full product.
- mul_a  out  16  operand A to the shared multiply cell.
- mul_b  out  16  operand B to the shared multiply cell.
- mul_p  in  32  unsigned product from the cell, MUL_LATENCY cycles after issue.
REQ-003 SHALL use one clock, and reset SHALL be asynchronous and active-low.

Function
REQ-004 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-005 IDLE: req_ready=1; req_valid&req_ready latches both operands, clears the 64-bit accumulator and moves to ISSUE.
REQ-006 ISSUE: exactly 4 cycles, issuing {a_lo,b_lo}, {a_hi,b_lo}, {a_lo,b_hi}, {a_hi,b_hi} in that order; then DRAIN.
REQ-007 A MUL_LATENCY-deep tag pipeline (valid + index 0..3) SHALL track each issued product; on tag valid, the accumulator adds mul_p shifted left 0, 16, 16 and 32 bits for index 0, 1, 2 and 3, modulo 2^64.
REQ-008 DRAIN: waits until the index-3 product is accumulated, then goes to DONE.
REQ-009 rsp_valid SHALL rise exactly 5+MUL_LATENCY rising edges after the accept edge, giving 6 at the default; latency SHALL NOT depend on data, including zero operands.
REQ-010 DONE: rsp_valid=1; rsp_result held stable until rsp_valid&rsp_ready; then IDLE on the next edge.
REQ-011 req_ready SHALL be 0 in ISSUE, DRAIN and DONE, so a request never overlaps with the response cycle; this costs one bubble per operation.
REQ-012 mul_a and mul_b SHALL be 0 outside ISSUE.
REQ-013 req_ready SHALL be combinational from state==IDLE; every other output SHALL be registered.

Reset
REQ-014 While reset_n=0, SHALL force: state IDLE, req_ready=1, rsp_valid=0, rsp_result=0, mul_a=mul_b=0, tag pipeline cleared, accumulator and operands 0.
REQ-015 Reset during any state SHALL abort the operation; products still in flight in the cell SHALL be ignored after reset release, because their tags are cleared.
REQ-016 The first request after release SHALL complete with nominal latency and a correct result.

Configuration
REQ-017 Macro MULT_SEQ_SIGNED_EN defined: adds input req_signed (1 bit), latched at accept. If set, the result SHALL be the two's-complement product: subtract (b<<32) when a[31]=1 and (a<<32) when b[31]=1, applied in the same cycle as the index-3 accumulation, with no extra latency.
REQ-018 Macro undefined: no req_signed port; all operands SHALL be unsigned.

Structure
REQ-019 Package eindopdracht_mult_seq_pkg SHALL hold: the FSM state enum, the tag struct (valid, 2-bit index), the partial-product shift table, and width constants 16, 32 and 64.
REQ-020 The tag pipeline plus accumulator SHALL be sub-module eindopdracht_mult_seq_acc; FSM, handshakes and operand muxing stay at the top level.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- 0xFFFFFFFF x 0xFFFFFFFF, unsigned -> rsp_result 0xFFFFFFFE00000001, rsp_valid exactly 6 edges after accept.
- 0x00012345 x 0x00010000 -> 0x0000000123450000; mul_a/mul_b sequence 0x2345/0x0000, 0x0001/0x0000, 0x2345/0x0001, 0x0001/0x0001.
- Result 0x3 x 0x5 with rsp_ready low for 10 cycles -> rsp_result=15 held stable and req_ready=0 throughout; after the handshake edge, req_ready=1.
- reset_n pulsed low in the 3rd ISSUE cycle -> all outputs at reset values; then 2 x 3 -> 6 with 6-edge latency and no stale product accumulated.
- With MULT_SEQ_SIGNED_EN: 0xFFFFFFFF x 0x00000002 with req_signed=1 -> 0xFFFFFFFFFFFFFFFE; with req_signed=0 -> 0x00000001FFFFFFFE.
- MUL_LATENCY=3 build: 7 x 9 -> 63, rsp_valid 8 edges after accept.
